// File: rtl/stream_record_collector_pkg.sv
// Shared types and default sizing for the stream record collector.
// The collector's own parameters may override the defaults kept here.
package stream_collector_pkg;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int DEF_NUM_ELEMENTS           = 4;
  localparam int DEF_DATA_BUS_WIDTH_BYTES   = 8;
  localparam int DEF_MAX_UNCOMPRESSED_BYTES = 34;

  localparam int BEATS_MAX =
    (DEF_MAX_UNCOMPRESSED_BYTES + DEF_DATA_BUS_WIDTH_BYTES - 1) / DEF_DATA_BUS_WIDTH_BYTES;
  localparam int BUF_BYTES = BEATS_MAX * DEF_DATA_BUS_WIDTH_BYTES;

  // Byte-valid mask of one beat at the default bus width.
  function automatic logic [DEF_DATA_BUS_WIDTH_BYTES-1:0] keep_for(int beat, int len);
    keep_for = '0;
    for (int i = 0; i < DEF_DATA_BUS_WIDTH_BYTES; i++) begin
      if ((beat * DEF_DATA_BUS_WIDTH_BYTES + i) < len) keep_for[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/stream_record_collector_if.sv
// AXI-Stream-style output bus of the record collector.
interface stream_record_collector_if
  import stream_collector_pkg::*;
#(
  parameter int W_BYTES = DEF_DATA_BUS_WIDTH_BYTES
);
  logic [W_BYTES*8-1:0] mDataOut;
  logic [W_BYTES-1:0]   mKeepOut;
  logic                 mValidOut;
  logic                 mReadyIn;
  logic                 mLastOut;

  modport master (
    output mDataOut, mKeepOut, mValidOut, mLastOut,
    input  mReadyIn
  );

  modport slave (
    input  mDataOut, mKeepOut, mValidOut, mLastOut,
    output mReadyIn
  );
endinterface

// File: rtl/stream_record_collector.sv
// Drains stream elements in strict token order into a holding buffer and
// serializes each record as W-byte beats on the output stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_WAIT | idle on element sel; captures once its length is nonzero
//   ST_SEND | emitting beats of the buffered record; element already freed
module stream_record_collector
  import stream_collector_pkg::*;
#(
  parameter int NUM_ELEMENTS           = DEF_NUM_ELEMENTS,
  parameter int DATA_BUS_WIDTH_BYTES   = DEF_DATA_BUS_WIDTH_BYTES,
  parameter int MAX_UNCOMPRESSED_BYTES = DEF_MAX_UNCOMPRESSED_BYTES,
  parameter int LEN_W                  = $clog2(MAX_UNCOMPRESSED_BYTES) + 1,
  parameter int SEL_W                  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   enable,
  input  logic [NUM_ELEMENTS-1:0][LEN_W-1:0]                     elemByteLengthIn,
  input  logic [NUM_ELEMENTS-1:0][MAX_UNCOMPRESSED_BYTES*8-1:0]  elemStreamIn,
  output logic [NUM_ELEMENTS-1:0]                                elemDataTaken,
  output logic [SEL_W-1:0]                                       currentElement,
  output logic [15:0]                                            recordCount,
  output logic                                                   lengthError,
  stream_record_collector_if.master                              m
);

  localparam int W      = DATA_BUS_WIDTH_BYTES;
  localparam int BEATS  = (MAX_UNCOMPRESSED_BYTES + W - 1) / W;
  localparam int BUFB   = BEATS * W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (BUFB > 1) ? $clog2(BUFB) : 1;

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [BUFB-1:0][7:0]      buf_q, buf_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [NUM_ELEMENTS-1:0]   taken_q, taken_d;
  logic [15:0]               rec_cnt_q, rec_cnt_d;
  logic                      len_err_q, len_err_d;

  logic                      send;
  logic                      last_beat;
  logic [W*8-1:0]            data_out;
  logic [W-1:0]              keep_out;
  logic [LEN_W-1:0]          sel_len;
  logic [BUFB*8-1:0]         capture;
  int                        idx;

  // Beat slicing: everything here depends only on flops, never on mReadyIn.
  always_comb begin
    send      = (state_q == ST_SEND);
    last_beat = ((int'(beat_q) + 1) * W) >= int'(len_q);
    data_out  = '0;
    keep_out  = '0;
    idx       = 0;
    for (int i = 0; i < W; i++) begin
      idx = int'(beat_q) * W + i;
      if (send && (idx < int'(len_q))) begin
        keep_out[i]         = 1'b1;
        data_out[i*8 +: 8]  = buf_q[IDX_W'(idx)];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    buf_d     = buf_q;
    len_d     = len_q;
    beat_d    = beat_q;
    taken_d   = '0;
    rec_cnt_d = rec_cnt_q;
    len_err_d = len_err_q;
    sel_len   = elemByteLengthIn[sel_q];
    capture   = (BUFB*8)'(elemStreamIn[sel_q]);

    case (state_q)
      ST_WAIT: begin
        if (enable && (sel_len != '0)) begin
          state_d = ST_SEND;
          buf_d   = capture;
          beat_d  = '0;
          taken_d = NUM_ELEMENTS'(1) << sel_q;
          if (sel_len > LEN_W'(MAX_UNCOMPRESSED_BYTES)) begin
            len_d     = LEN_W'(MAX_UNCOMPRESSED_BYTES);
            len_err_d = 1'b1;
          end else begin
            len_d = sel_len;
          end
        end
      end
      ST_SEND: begin
        if (m.mReadyIn) begin
          if (last_beat) begin
            state_d   = ST_WAIT;
            rec_cnt_d = rec_cnt_q + 16'd1;
            sel_d     = (sel_q == SEL_W'(NUM_ELEMENTS - 1)) ? '0 : sel_q + SEL_W'(1);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_WAIT;
      sel_q     <= '0;
      buf_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      taken_q   <= '0;
      rec_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      buf_q     <= buf_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      taken_q   <= taken_d;
      rec_cnt_q <= rec_cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign m.mValidOut     = send;
  assign m.mLastOut      = send && last_beat;
  assign m.mDataOut      = data_out;
  assign m.mKeepOut      = keep_out;
  assign elemDataTaken   = taken_q;
  assign currentElement  = sel_q;
  assign recordCount     = rec_cnt_q;
  assign lengthError     = len_err_q;

endmodule

// File: tb/tb_stream_record_collector.sv
// Self-checking bench: element model, table of records, scoreboard of beats.
module tb_stream_record_collector;
  import stream_collector_pkg::*;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MAXB  = 34;
  localparam int LEN_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic [N-1:0][LEN_W-1:0]  len_in;
  logic [N-1:0][MAXB*8-1:0] stream_in;
  logic [N-1:0]             taken;
  logic [1:0]               cur;
  logic [15:0]              rec_cnt;
  logic                     len_err;

  always #5 clk = ~clk;

  stream_record_collector_if #(.W_BYTES(W)) m_if();

  stream_record_collector dut (
    .clk              (clk),
    .reset            (rst_n),
    .enable           (enable),
    .elemByteLengthIn (len_in),
    .elemStreamIn     (stream_in),
    .elemDataTaken    (taken),
    .currentElement   (cur),
    .recordCount      (rec_cnt),
    .lengthError      (len_err),
    .m                (m_if.master)
  );

  // Element model: length + bytes, cleared when the release pulse is sampled.
  logic [LEN_W-1:0] elem_len   [N];
  logic [7:0]       elem_bytes [N][MAXB];

  always_comb begin
    for (int e = 0; e < N; e++) begin
      len_in[e] = elem_len[e];
      for (int k = 0; k < MAXB; k++) stream_in[e][k*8 +: 8] = elem_bytes[e][k];
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int elem;
    int len;
    int seed;
    int beats;
    int last_keep;
    int err;
  } row_t;

  beat_t exp_q[$];
  int    taken_log[$];
  int    exp_taken[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    xfer_cnt = 0;
  logic [7:0]  last_keep;
  logic        prev_valid, prev_ready;
  logic [63:0] prev_data;
  logic [8:0]  prev_kl;
  logic [N-1:0] prev_taken;
  row_t rows[7];

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic monitor();
    beat_t e;
    int ti;
    if (prev_valid && !prev_ready) begin
      check("hold_valid", m_if.mValidOut, 1);
      check("hold_data", m_if.mDataOut, prev_data);
      check("hold_keep_last", {m_if.mKeepOut, m_if.mLastOut}, prev_kl);
    end
    if (prev_taken != '0) check("taken_pulse_width", taken, 0);
    if (taken != '0) begin
      check("taken_onehot", $onehot(taken), 1);
      ti = 0;
      for (int k = 0; k < N; k++) if (taken[k]) ti = k;
      taken_log.push_back(ti);
    end
    if (m_if.mValidOut && m_if.mReadyIn) begin
      xfer_cnt++;
      last_keep = m_if.mKeepOut;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, expected no beat",
                 m_if.mDataOut, m_if.mKeepOut);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", m_if.mDataOut, e.data);
        check("beat_keep", m_if.mKeepOut, e.keep);
        check("beat_last", m_if.mLastOut, e.last);
      end
    end
    prev_valid = m_if.mValidOut;
    prev_ready = m_if.mReadyIn;
    prev_data  = m_if.mDataOut;
    prev_kl    = {m_if.mKeepOut, m_if.mLastOut};
    prev_taken = taken;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int e = 0; e < N; e++) if (prev_taken[e]) elem_len[e] = '0;
  endtask

  task automatic fill(int e, int len, int seed);
    elem_len[e] = LEN_W'(len);
    for (int k = 0; k < MAXB; k++) elem_bytes[e][k] = 8'(seed + k);
  endtask

  task automatic push_record(int e, int len, int seed);
    int elen, nb, k;
    beat_t x;
    elen = (len > MAXB) ? MAXB : len;
    nb   = (elen + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      x.data = '0;
      x.keep = '0;
      for (int i = 0; i < W; i++) begin
        k = b * W + i;
        if (k < elen) begin
          x.data[i*8 +: 8] = 8'(seed + k);
          x.keep[i]        = 1'b1;
        end
      end
      x.last = (b == nb - 1);
      exp_q.push_back(x);
    end
    exp_taken.push_back(e);
  endtask

  task automatic compare_taken(string name);
    check({name, "_taken_count"}, taken_log.size(), exp_taken.size());
    for (int i = 0; i < exp_taken.size() && i < taken_log.size(); i++)
      check({name, "_taken_order"}, taken_log[i], exp_taken[i]);
    taken_log.delete();
    exp_taken.delete();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic wait_xfers(string name, int target, int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check(name, (xfer_cnt >= target), 1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", m_if.mValidOut, 0);
    check("rst_last", m_if.mLastOut, 0);
    check("rst_keep", m_if.mKeepOut, 0);
    check("rst_data", m_if.mDataOut, 0);
    check("rst_taken", taken, 0);
    check("rst_cur", cur, 0);
    check("rst_rec_cnt", rec_cnt, 0);
    check("rst_len_err", len_err, 0);
    exp_q.delete();
    taken_log.delete();
    exp_taken.delete();
    for (int e = 0; e < N; e++) elem_len[e] = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_taken = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    enable       = 1'b1;
    m_if.mReadyIn = 1'b1;
    xfer_cnt     = 0;
  endtask

  initial begin
    rst_n         = 1'b1;
    enable        = 1'b1;
    m_if.mReadyIn = 1'b1;
    prev_valid    = 1'b0;
    prev_ready    = 1'b1;
    prev_taken    = '0;
    last_keep     = '0;
    for (int e = 0; e < N; e++) fill(e, 0, 0);

    rows[0] = '{0, 23, 'h00, 3, 'h7F, 0};
    rows[1] = '{1,  8, 'h40, 1, 'hFF, 0};
    rows[2] = '{2, 34, 'h80, 5, 'h03, 0};
    rows[3] = '{3,  1, 'hC0, 1, 'h01, 0};
    rows[4] = '{0, 40, 'h10, 5, 'h03, 1};
    rows[5] = '{1, 16, 'h55, 2, 'hFF, 1};
    rows[6] = '{2,  9, 'hA0, 2, 'h01, 1};

    #2;
    apply_reset();

    // Table of single records served in token order.
    for (int r = 0; r < 7; r++) begin
      xfer_cnt = 0;
      fill(rows[r].elem, rows[r].len, rows[r].seed);
      push_record(rows[r].elem, rows[r].len, rows[r].seed);
      drain(200);
      check("row_beats", xfer_cnt, rows[r].beats);
      check("row_last_keep", last_keep, rows[r].last_keep);
      check("row_len_err", len_err, rows[r].err);
      check("row_rec_cnt", rec_cnt, r + 1);
      check("row_cur", cur, (rows[r].elem + 1) % N);
      compare_taken("row");
    end

    // Backpressure held at beat 2.
    apply_reset();
    fill(0, 20, 'h30);
    push_record(0, 20, 'h30);
    wait_xfers("bp_first_beat", 1, 20);
    m_if.mReadyIn = 1'b0;
    repeat (5) cycle();
    check("bp_no_xfer_stalled", xfer_cnt, 1);
    m_if.mReadyIn = 1'b1;
    drain(50);
    check("bp_total_xfers", xfer_cnt, 3);
    compare_taken("bp");

    // Ordering: a full non-selected element is never skipped to.
    apply_reset();
    fill(2, 12, 'h70);
    repeat (20) cycle();
    check("ord_idle_xfers", xfer_cnt, 0);
    check("ord_idle_cur", cur, 0);
    check("ord_idle_taken", taken_log.size(), 0);
    check("ord_elem2_kept", elem_len[2], 12);
    fill(0, 5, 'h01);
    fill(1, 17, 'h21);
    fill(3, 30, 'h61);
    push_record(0, 5, 'h01);
    push_record(1, 17, 'h21);
    push_record(2, 12, 'h70);
    push_record(3, 30, 'h61);
    drain(300);
    compare_taken("ord");
    fill(0, 3, 'h99);
    push_record(0, 3, 'h99);
    drain(50);
    compare_taken("ord_wrap");
    check("ord_rec_cnt", rec_cnt, 5);
    check("ord_cur", cur, 1);

    // Enable gating.
    apply_reset();
    enable = 1'b0;
    fill(0, 16, 'h11);
    repeat (10) cycle();
    check("en_no_xfer", xfer_cnt, 0);
    check("en_no_taken", taken_log.size(), 0);
    check("en_elem0_kept", elem_len[0], 16);
    enable = 1'b1;
    push_record(0, 16, 'h11);
    drain(50);
    xfer_cnt = 0;
    fill(1, 24, 'h22);
    fill(2, 8, 'h33);
    push_record(1, 24, 'h22);
    begin
      int n = 0;
      while (taken_log.size() < 2 && n < 20) begin
        cycle();
        n++;
      end
      check("en_second_started", taken_log.size(), 2);
    end
    enable = 1'b0;
    drain(50);
    repeat (10) cycle();
    check("en_inflight_beats", xfer_cnt, 3);
    check("en_rec_cnt", rec_cnt, 2);
    check("en_cur", cur, 2);
    check("en_elem2_kept", elem_len[2], 8);
    compare_taken("en");

    // Asynchronous reset in the middle of a record.
    apply_reset();
    fill(0, 23, 'h05);
    push_record(0, 23, 'h05);
    wait_xfers("rst_mid_first_beat", 1, 20);
    check("rst_mid_valid_before", m_if.mValidOut, 1);
    apply_reset();
    check("rst_mid_cur", cur, 0);
    fill(1, 8, 'h44);
    fill(0, 8, 'h55);
    push_record(0, 8, 'h55);
    push_record(1, 8, 'h44);
    drain(50);
    compare_taken("rst_mid");
    check("rst_mid_rec_cnt", rec_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
